// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BYTE  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } sccb_state_t;

  localparam logic [7:0] OV5640_SCCB_WR_ADDR = 8'h78;

  localparam int CFG_ADDR_MSB = 23;
  localparam int CFG_ADDR_LSB = 8;
  localparam int CFG_VAL_MSB  = 7;

  // Pad levels {scl, sda_oe} for a given state, quarter and outgoing data bit.
  function automatic logic [1:0] sccb_pins(input sccb_state_t st, input logic [1:0] q,
                                           input logic b);
    logic [1:0] pins;
    pins = 2'b10;
    case (st)
      START:   pins = (q == 2'd2) ? 2'b11 : ((q == 2'd3) ? 2'b01 : 2'b10);
      BYTE:    pins = {(q == 2'd1) || (q == 2'd2), ~b};
      ACK:     pins = {(q == 2'd1) || (q == 2'd2), 1'b0};
      STOP:    pins = (q == 2'd0) ? 2'b01 : ((q == 2'd1) ? 2'b11 : 2'b10);
      default: pins = 2'b10;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/sccb_qtick.sv
// Quarter-bit timebase: counts 0..QCNT-1 while enabled, ticks on wrap and
// tracks which quarter (0..3) of the bit period is in progress.
module sccb_qtick #(
  parameter int QCNT = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = (QCNT > 2) ? $clog2(QCNT) : 1;

  logic [CW-1:0] cnt_r;
  logic [1:0]    q_r;

  assign tick    = en && (cnt_r == CW'(QCNT - 1));
  assign quarter = q_r;

  // Counter and quarter index; both held at zero while disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= '0;
      q_r   <= 2'd0;
    end else if (!en) begin
      cnt_r <= '0;
      q_r   <= 2'd0;
    end else if (tick) begin
      cnt_r <= '0;
      q_r   <= q_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/ov5640_sccb_wr.sv
// SCCB write master: serialises {DEV_ADDR, reg_addr, reg_val} as one
// START / 4 bytes with ACK / STOP transaction and pulses cfg_end when done.
module ov5640_sccb_wr
  import ov5640_pkg::*;
#(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter logic [7:0] DEV_ADDR     = OV5640_SCCB_WR_ADDR
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err
);

  localparam int QCNT = SYS_CLK_FREQ / (4 * SCL_FREQ);

  sccb_state_t state_r, state_nx;
  logic        busy_r, cfg_end_r, ack_err_r, nack_r;
  logic [31:0] sh_r;
  logic [1:0]  byte_idx_r;
  logic [2:0]  bit_idx_r;
  logic        sda_meta_r, sda_sync_r;
  logic        scl_r, sda_oe_r;
  logic        tick_s;
  logic [1:0]  quarter_s;
  logic        accept_s, end_q_s, mid_s;

  assign accept_s = cfg_start && !busy_r;
  assign end_q_s  = tick_s && (quarter_s == 2'd3);
  assign mid_s    = tick_s && (quarter_s == 2'd1);

  assign scl     = scl_r;
  assign sda_oe  = sda_oe_r;
  assign cfg_end = cfg_end_r;
  assign busy    = busy_r;
  assign ack_err = ack_err_r;

  sccb_qtick #(.QCNT(QCNT)) u_qtick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (busy_r),
    .tick      (tick_s),
    .quarter   (quarter_s)
  );

  // Two-flop synchroniser for the SDA pad input.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
    end else begin
      sda_meta_r <= sda_i;
      sda_sync_r <= sda_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state; every phase advances only on the last quarter of a bit.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = accept_s ? START : IDLE;
      START:   state_nx = end_q_s ? BYTE : START;
      BYTE:    state_nx = (end_q_s && (bit_idx_r == 3'd7)) ? ACK : BYTE;
      ACK: begin
        if (end_q_s) begin
          state_nx = (nack_r || (byte_idx_r == 2'd3)) ? STOP : BYTE;
        end else begin
          state_nx = ACK;
        end
      end
      STOP:    state_nx = end_q_s ? DONE : STOP;
      DONE:    state_nx = accept_s ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift register, counters, handshake flags and ACK sampling.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_r       <= 32'd0;
      byte_idx_r <= 2'd0;
      bit_idx_r  <= 3'd0;
      busy_r     <= 1'b0;
      cfg_end_r  <= 1'b0;
      ack_err_r  <= 1'b0;
      nack_r     <= 1'b0;
    end else begin
      cfg_end_r <= 1'b0;
      if (accept_s) begin
        sh_r       <= {DEV_ADDR, cfg_data[CFG_ADDR_MSB:CFG_ADDR_LSB], cfg_data[CFG_VAL_MSB:0]};
        byte_idx_r <= 2'd0;
        bit_idx_r  <= 3'd0;
        ack_err_r  <= 1'b0;
        nack_r     <= 1'b0;
        busy_r     <= 1'b1;
      end else begin
        case (state_r)
          BYTE: begin
            if (end_q_s) begin
              sh_r      <= {sh_r[30:0], 1'b0};
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
          ACK: begin
            if (mid_s) begin
              nack_r <= sda_sync_r;
              if (sda_sync_r) begin
                ack_err_r <= 1'b1;
              end
            end
            if (end_q_s && !nack_r && (byte_idx_r != 2'd3)) begin
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
          STOP: begin
            if (end_q_s) begin
              cfg_end_r <= 1'b1;
              busy_r    <= 1'b0;
            end
          end
          default: begin
            nack_r <= nack_r;
          end
        endcase
      end
    end
  end

  // Registered pad drivers derived from the current phase and quarter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_r    <= 1'b1;
      sda_oe_r <= 1'b0;
    end else begin
      {scl_r, sda_oe_r} <= sccb_pins(state_r, quarter_s, sh_r[31]);
    end
  end

endmodule
